// File: rtl/stopwatch_if.sv
// Key levels in, run/display status out for the stopwatch controller.
// Keys are plain debounced levels; no valid/ready handshake is involved.
interface stopwatch_if;
  logic       key_ss;
  logic       key_lr;
  logic       run;
  logic       lap_hold;
  logic       ovf;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  logic [1:0] state;

  modport master (
    output key_ss, key_lr,
    input  run, lap_hold, ovf, disp_min, disp_sec, disp_cs, state
  );

  modport slave (
    input  key_ss, key_lr,
    output run, lap_hold, ovf, disp_min, disp_sec, disp_cs, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM with 10 ms prescaler, BCD MM:SS.cc time base,
// lap capture and display selection.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic      clk,
  input  logic      rst,
  stopwatch_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          k1_ss, k2_ss, k1_lr, k2_lr;
  logic          ss_edge, lr_edge;
  logic          capture, clear, counting, tick;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    live_min, live_sec, live_cs;
  logic [7:0]    lap_min, lap_sec, lap_cs;
  logic [7:0]    cs_inc, sec_inc, min_inc;
  logic [7:0]    sec_nxt, min_nxt;
  logic          c_cs, c_sec, c_min, wrap;
  logic          ovf_q;

  // Returns {carry, next}; the digit pair rolls to 00 when it equals top.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [8:0] r;
    if (v == top)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'h9)
      r = {1'b0, v[7:4] + 4'h1, 4'h0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  // Key synchronisers run through reset so a key held across reset gives no edge.
  always_ff @(posedge clk) begin
    k1_ss <= bus.key_ss;
    k2_ss <= k1_ss;
    k1_lr <= bus.key_lr;
    k2_lr <= k1_lr;
  end

  assign ss_edge  = k1_ss & ~k2_ss;
  assign lr_edge  = k1_lr & ~k2_lr;
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (pre_q == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Start/stop has priority over lap/reset when both edges coincide.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_edge) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_edge) begin
          state_d = S_PAUSE;
        end else if (lr_edge) begin
          state_d = S_LAP;
          capture = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_edge)      state_d = S_PAUSE;
        else if (lr_edge) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_edge) begin
          state_d = S_RUN;
        end else if (lr_edge) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler holds in PAUSE so the sub-tick phase survives a pause.
  always_comb begin
    pre_d = pre_q;
    case (state_q)
      S_RUN, S_LAP: pre_d = tick ? '0 : pre_q + PW'(1);
      S_PAUSE:      pre_d = clear ? '0 : pre_q;
      default:      pre_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  always_comb begin
    {c_cs, cs_inc}   = bcd_inc(live_cs, 8'h99);
    {c_sec, sec_inc} = bcd_inc(live_sec, 8'h59);
    {c_min, min_inc} = bcd_inc(live_min, 8'h59);
    sec_nxt = c_cs ? sec_inc : live_sec;
    min_nxt = (c_cs && c_sec) ? min_inc : live_min;
    wrap    = c_cs && c_sec && c_min;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      live_min <= 8'h00;
      live_sec <= 8'h00;
      live_cs  <= 8'h00;
      ovf_q    <= 1'b0;
    end else if (tick) begin
      live_min <= min_nxt;
      live_sec <= sec_nxt;
      live_cs  <= cs_inc;
      ovf_q    <= ovf_q | wrap;
    end
  end

  // Capture uses the pre-update live value even when a tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_min <= 8'h00;
      lap_sec <= 8'h00;
      lap_cs  <= 8'h00;
    end else if (capture) begin
      lap_min <= live_min;
      lap_sec <= live_sec;
      lap_cs  <= live_cs;
    end
  end

  always_comb begin
    bus.disp_min = live_min;
    bus.disp_sec = live_sec;
    bus.disp_cs  = live_cs;
    if (state_q == S_LAP) begin
      bus.disp_min = lap_min;
      bus.disp_sec = lap_sec;
      bus.disp_cs  = lap_cs;
    end
  end

  assign bus.run      = counting;
  assign bus.lap_hold = (state_q == S_LAP);
  assign bus.ovf      = ovf_q;
  assign bus.state    = state_q;

endmodule
